load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 40 ++++
 rtl/load_store_unit_load_extend.sv | 38 +++
 rtl/load_store_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - funct3 width codes, FSM state encoding and access-geometry helpers
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS1 = 2'd1,
    ACCESS2 = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Width codes 011/110/111 do not exist; stores have no unsigned variants.
  function automatic logic illegal_funct3(input logic write, input logic [2:0] funct3);
    return (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (write && funct3[2]);
  endfunction

  // Byte-lane pattern of an access at offset 0, indexed by the low two funct3 bits.
  function automatic logic [3:0] lane_base(input logic [1:0] width);
    case (width)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // An access is misaligned when it crosses a word boundary.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] offset);
    case (width)
      2'b00:   return 1'b0;
      2'b01:   return offset == 2'd3;
      default: return offset != 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// rtl/load_store_unit_load_extend.sv - byte select and sign/zero extension of a load result
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [55:0] words,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] stream;

  // Pick the four bytes starting at the access offset; bytes past a second word are never needed.
  always_comb begin
    stream = words[31:0];
    case (offset)
      2'd0: stream = words[31:0];
      2'd1: stream = words[39:8];
      2'd2: stream = words[47:16];
      2'd3: stream = words[55:24];
      default: stream = words[31:0];
    endcase
  end

  // Keep the access size and extend according to the width code.
  always_comb begin
    data = stream;
    case (funct3)
      F3_B:    data = {{24{stream[7]}}, stream[7:0]};
      F3_H:    data = {{16{stream[15]}}, stream[15:0]};
      F3_BU:   data = {24'd0, stream[7:0]};
      F3_HU:   data = {16'd0, stream[15:0]};
      F3_W:    data = stream;
      default: data = stream;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 load/store unit with optional split of word-crossing accesses
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_write_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_mask,
  input  logic [31:0] mem_read_data
);

  state_t      state, state_next;
  logic        op_write, op_error, op_split, req_reject;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr, op_wdata, word_lo, load_data;
  logic [23:0] word_hi;
  logic [29:0] word_index;
  logic [7:0]  lane_span;
  logic [63:0] data_span;

  assign req_reject = illegal_funct3(req_write, req_funct3) ||
                      (MISALIGN_SPLIT == 0 && misaligned(req_funct3[1:0], req_addr[1:0]));
  assign op_split   = misaligned(op_funct3[1:0], op_addr[1:0]);
  assign word_index = op_addr[31:2];
  // Low halves go to the first word, anything shifted past lane 3 spills into the second.
  assign lane_span  = {4'b0000, lane_base(op_funct3[1:0])} << op_addr[1:0];
  assign data_span  = {32'd0, op_wdata} << {op_addr[1:0], 3'b000};

  load_extend u_load_extend (
    .words  ({word_hi, word_lo}),
    .offset (op_addr[1:0]),
    .funct3 (op_funct3),
    .data   (load_data)
  );

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Request capture and load-word capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_write  <= 1'b0;
      op_error  <= 1'b0;
      op_funct3 <= 3'd0;
      op_addr   <= 32'd0;
      op_wdata  <= 32'd0;
      word_lo   <= 32'd0;
      word_hi   <= 24'd0;
    end else begin
      if (state == IDLE && req_valid) begin
        op_write  <= req_write;
        op_error  <= req_reject;
        op_funct3 <= req_funct3;
        op_addr   <= req_addr;
        op_wdata  <= req_wdata;
      end
      if (state == ACCESS1 && !op_write) word_lo <= mem_read_data;
      if (state == ACCESS2 && !op_write) word_hi <= mem_read_data[23:0];
    end
  end

  // Next-state and all outputs; memory signals are driven only during access cycles.
  always_comb begin
    state_next       = state;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_rdata       = 32'd0;
    resp_error       = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = 32'd0;
    mem_write_data   = 32'd0;
    mem_write_mask   = 4'd0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_reject ? RESP : ACCESS1;
      end
      ACCESS1: begin
        mem_write_enable = op_write;
        mem_address      = {2'b00, word_index};
        mem_write_mask   = lane_span[3:0];
        mem_write_data   = data_span[31:0];
        state_next       = op_split ? ACCESS2 : RESP;
      end
      ACCESS2: begin
        mem_write_enable = op_write;
        mem_address      = {2'b00, word_index + 30'd1};
        mem_write_mask   = lane_span[7:4];
        mem_write_data   = data_span[63:32];
        state_next       = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_error = op_error;
        resp_rdata = (op_write || op_error) ? 32'd0 : load_data;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
